// File: rtl/ticket_vend_ctrl.sv
// Transit ticket machine controller: accumulates bills against TIXCOST*qty, pays change or
// refunds in $10/$5 units and dispenses tickets, each unit over a request/ack handshake.
module ticket_vend_ctrl #(
  parameter int TIXCOST     = 40,
  parameter int MAX_QTY     = 4,
  parameter int TOTAL_W     = 10,
  parameter int TIMEOUT_CYC = 1000,
  localparam int QTY_W      = $clog2(MAX_QTY + 1),
  localparam int TMO_W      = $clog2(TIMEOUT_CYC)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               bill_valid_i,
  input  logic [1:0]         bill_code_i,
  input  logic [QTY_W-1:0]   qty_i,
  input  logic               cancel_i,
  input  logic               change_ack_i,
  input  logic               tix_ack_i,
  output logic               ready_o,
  output logic               bill_o,
  output logic               return_ten_o,
  output logic               return_five_o,
  output logic               dispense_o,
  output logic               refunding_o,
  output logic               bill_reject_o,
  output logic [TOTAL_W-1:0] credit_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_CHANGE   = 3'd2;
  localparam logic [2:0] S_DISPENSE = 3'd3;
  localparam logic [2:0] S_REFUND   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [TOTAL_W-1:0] credit_q, credit_d;
  logic [TOTAL_W-1:0] price_q, price_d;
  logic [TOTAL_W-1:0] change_q, change_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic [QTY_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               ten_q, ten_d;
  logic               five_q, five_d;
  logic               disp_q, disp_d;
  logic               rej_q, rej_d;

  logic [TOTAL_W-1:0] bill_val;
  logic [TOTAL_W:0]   bill_sum;
  logic               bill_ok;
  logic [QTY_W-1:0]   qty_eff;
  logic [TOTAL_W-1:0] price_new;
  logic [TOTAL_W-1:0] unit_val;

  always_comb begin
    bill_val = TOTAL_W'(50);
    case (bill_code_i)
      2'd0:    bill_val = TOTAL_W'(5);
      2'd1:    bill_val = TOTAL_W'(10);
      2'd2:    bill_val = TOTAL_W'(20);
      default: bill_val = TOTAL_W'(50);
    endcase
  end

  // One extra bit catches accumulator overflow before the bill is accepted.
  assign bill_sum = {1'b0, credit_q} + {1'b0, bill_val};

  always_comb begin
    bill_ok = 1'b0;
    if (bill_valid_i && !bill_sum[TOTAL_W]) begin
      if (state_q == S_IDLE) begin
        bill_ok = 1'b1;
      end else if (state_q == S_COLLECT && !cancel_i && credit_q < price_q) begin
        bill_ok = 1'b1;
      end
    end
  end

  always_comb begin
    qty_eff = qty_i;
    if (qty_i == '0) begin
      qty_eff = QTY_W'(1);
    end else if (qty_i > QTY_W'(MAX_QTY)) begin
      qty_eff = QTY_W'(MAX_QTY);
    end
  end

  assign price_new = TOTAL_W'(TIXCOST) * TOTAL_W'(qty_eff);
  assign unit_val  = ten_q ? TOTAL_W'(10) : TOTAL_W'(5);
  assign rej_d     = bill_valid_i & ~bill_ok;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    change_d = change_q;
    qty_d    = qty_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    ten_d    = ten_q;
    five_d   = five_q;
    disp_d   = disp_q;

    case (state_q)
      S_IDLE: begin
        if (bill_ok) begin
          credit_d = bill_sum[TOTAL_W-1:0];
          price_d  = price_new;
          qty_d    = qty_eff;
          cnt_d    = '0;
          tmo_d    = '0;
          state_d  = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // Once the registered credit covers the price the sale is committed.
        if (credit_q == price_q) begin
          cnt_d   = '0;
          state_d = S_DISPENSE;
        end else if (credit_q > price_q) begin
          change_d = credit_q - price_q;
          state_d  = S_CHANGE;
        end else if (cancel_i) begin
          change_d = credit_q;
          state_d  = S_REFUND;
        end else if (bill_ok) begin
          credit_d = bill_sum[TOTAL_W-1:0];
          tmo_d    = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          change_d = credit_q;
          state_d  = S_REFUND;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_CHANGE, S_REFUND: begin
        if (ten_q || five_q) begin
          if (change_ack_i) begin
            ten_d    = 1'b0;
            five_d   = 1'b0;
            change_d = change_q - unit_val;
            if (state_q == S_REFUND) begin
              credit_d = credit_q - unit_val;
            end
          end
        end else if (change_q >= TOTAL_W'(10)) begin
          ten_d = 1'b1;
        end else if (change_q >= TOTAL_W'(5)) begin
          five_d = 1'b1;
        end else if (state_q == S_CHANGE) begin
          cnt_d   = '0;
          state_d = S_DISPENSE;
        end else begin
          credit_d = '0;
          price_d  = '0;
          qty_d    = '0;
          cnt_d    = '0;
          tmo_d    = '0;
          state_d  = S_IDLE;
        end
      end

      S_DISPENSE: begin
        if (disp_q) begin
          if (tix_ack_i) begin
            disp_d = 1'b0;
            cnt_d  = cnt_q + QTY_W'(1);
          end
        end else if (cnt_q != qty_q) begin
          disp_d = 1'b1;
        end else begin
          credit_d = '0;
          price_d  = '0;
          qty_d    = '0;
          cnt_d    = '0;
          tmo_d    = '0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      price_q  <= '0;
      change_q <= '0;
      qty_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      ten_q    <= 1'b0;
      five_q   <= 1'b0;
      disp_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      change_q <= change_d;
      qty_q    <= qty_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      ten_q    <= ten_d;
      five_q   <= five_d;
      disp_q   <= disp_d;
      rej_q    <= rej_d;
    end
  end

  assign ready_o       = (state_q == S_IDLE);
  assign bill_o        = (state_q == S_COLLECT);
  assign refunding_o   = (state_q == S_REFUND);
  assign return_ten_o  = ten_q;
  assign return_five_o = five_q;
  assign dispense_o    = disp_q;
  assign bill_reject_o = rej_q;
  assign credit_o      = credit_q;

endmodule
